// File: rtl/sr595_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sr595_chain_ctrl
//  Purpose  : Drives a daisy chain of N_CHIPS 74LV595 shift/storage registers.
//             Accepts a parallel frame on a valid/ready handshake, shifts it
//             out MSB-first on SER/SRCLK at a divided rate, pulses RCLK to
//             latch it, and manages SRCLRn (cleared at init) and OEn.
//  Options  : `define SR595_READBACK_EN captures QH of the last chip while
//             shifting and presents the previous chain contents on rd_data.
//  Revision : 1.0 - initial release
// ============================================================================
module sr595_chain_ctrl #(
    parameter int N_CHIPS = 2,
    parameter int CLK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*N_CHIPS-1:0]   in_data,
    input  logic                   out_enable,
    output logic                   done,
    output logic                   sr_ser,
    output logic                   sr_srclk,
    output logic                   sr_rclk,
    output logic                   sr_srclrn,
    output logic                   sr_oen,
    input  logic                   sr_qh,
    output logic [8*N_CHIPS-1:0]   rd_data
);

    localparam int W  = 8 * N_CHIPS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(W);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_INIT_LO    = 3'd0,
        S_INIT_HI    = 3'd1,
        S_INIT_LATCH = 3'd2,
        S_IDLE       = 3'd3,
        S_SHIFT_LO   = 3'd4,
        S_SHIFT_HI   = 3'd5,
        S_LATCH      = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [W-1:0]    data_q, data_d;
    logic            init_done_q, init_done_d;
    logic            in_ready_q, in_ready_d;
    logic            done_q, done_d;
    logic            ser_q, ser_d;
    logic            srclk_q, srclk_d;
    logic            rclk_q, rclk_d;
    logic            srclrn_q, srclrn_d;
    logic            oen_q, oen_d;
    logic            phase_last;

    assign phase_last = (phase_q == PH_LAST);

    // State, sequencing and registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT_LO;
            phase_q     <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            init_done_q <= 1'b0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            ser_q       <= 1'b0;
            srclk_q     <= 1'b0;
            rclk_q      <= 1'b0;
            srclrn_q    <= 1'b0;
            oen_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
            ser_q       <= ser_d;
            srclk_q     <= srclk_d;
            rclk_q      <= rclk_d;
            srclrn_q    <= srclrn_d;
            oen_q       <= oen_d;
        end
    end

    // Next-state logic; pin values are decoded from the next state so each
    // registered output lines up with the state it belongs to
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_last ? '0 : phase_q + PW'(1);
        bit_d       = bit_q;
        data_d      = data_q;
        init_done_d = init_done_q;

        case (state_q)
            S_INIT_LO: begin
                if (phase_last) state_d = S_INIT_HI;
            end
            S_INIT_HI: begin
                if (phase_last) state_d = S_INIT_LATCH;
            end
            S_INIT_LATCH: begin
                if (phase_last) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                phase_d = '0;
                if (in_valid && in_ready_q) begin
                    data_d  = in_data;
                    bit_d   = BW'(W - 1);
                    state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (phase_last) state_d = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                if (phase_last) begin
                    if (bit_q == '0) begin
                        state_d = S_LATCH;
                    end else begin
                        bit_d   = bit_q - BW'(1);
                        data_d  = {data_q[W-2:0], 1'b0};
                        state_d = S_SHIFT_LO;
                    end
                end
            end
            S_LATCH: begin
                if (phase_last) state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT_LO;
                phase_d = '0;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        srclk_d    = (state_d == S_INIT_HI) || (state_d == S_SHIFT_HI);
        rclk_d     = (state_d == S_INIT_LATCH) || (state_d == S_LATCH);
        srclrn_d   = !((state_d == S_INIT_LO) || (state_d == S_INIT_HI));
        done_d     = (state_d == S_LATCH) && (phase_d == PH_LAST);
        // SER only moves when entering/within SHIFT_LO, so it is stable at every SRCLK rise
        ser_d      = (state_d == S_SHIFT_LO) ? data_d[W-1] : ser_q;
        oen_d      = init_done_d ? ~out_enable : 1'b1;
    end

    assign in_ready  = in_ready_q;
    assign done      = done_q;
    assign sr_ser    = ser_q;
    assign sr_srclk  = srclk_q;
    assign sr_rclk   = rclk_q;
    assign sr_srclrn = srclrn_q;
    assign sr_oen    = oen_q;

`ifdef SR595_READBACK_EN
    logic [W-1:0] cap_q, cap_d;
    logic [W-1:0] rd_q, rd_d;

    // QH is sampled just before each SRCLK rise; the first sample is the old MSB
    always_comb begin
        cap_d = cap_q;
        rd_d  = rd_q;
        if (state_q == S_SHIFT_LO && phase_last) cap_d = {cap_q[W-2:0], sr_qh};
        if (done_d) rd_d = cap_q;
    end

    // Capture and readback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q <= '0;
            rd_q  <= '0;
        end else begin
            cap_q <= cap_d;
            rd_q  <= rd_d;
        end
    end

    assign rd_data = rd_q;
`else
    logic unused_qh;
    assign unused_qh = sr_qh;
    assign rd_data   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr595_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr595_chain_ctrl
//  Purpose  : Self-checking bench for sr595_chain_ctrl with a behavioural
//             74LV595 chain model on the pin interface.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr595_chain_ctrl;

    localparam int N_CHIPS = 2;
    localparam int CLK_DIV = 2;
    localparam int W       = 8 * N_CHIPS;
    localparam int BUSY    = 2 * CLK_DIV * W + CLK_DIV + 1;
    localparam int INITLEN = 3 * CLK_DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_enable = 1'b1;
    logic          done;
    logic          sr_ser, sr_srclk, sr_rclk, sr_srclrn, sr_oen;
    logic          sr_qh;
    logic [W-1:0]  rd_data;

    int checks   = 0;
    int failures = 0;

    sr595_chain_ctrl #(.N_CHIPS(N_CHIPS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_enable(out_enable), .done(done),
        .sr_ser(sr_ser), .sr_srclk(sr_srclk), .sr_rclk(sr_rclk),
        .sr_srclrn(sr_srclrn), .sr_oen(sr_oen), .sr_qh(sr_qh), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural 595 chain, sampled mid-cycle ----------------
    logic [W-1:0] chain   = '0;
    logic [W-1:0] storage = '0;
    logic srclk_prev = 1'b0, rclk_prev = 1'b0, done_prev = 1'b0, ser_prev = 1'b0;
    int srclk_rises = 0, rclk_rises = 0, done_cnt = 0, done_viol = 0, ser_viol = 0;

    assign sr_qh = chain[W-1];

    always @(negedge clk) begin
        if (!sr_srclrn) chain <= '0;
        else if (sr_srclk && !srclk_prev) begin
            chain       <= {chain[W-2:0], sr_ser};
            srclk_rises <= srclk_rises + 1;
        end
        if (sr_rclk && !rclk_prev) begin
            storage    <= chain;
            rclk_rises <= rclk_rises + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (done && done_prev) done_viol <= done_viol + 1;
        if (sr_ser != ser_prev && sr_srclk) ser_viol <= ser_viol + 1;
        srclk_prev <= sr_srclk;
        rclk_prev  <= sr_rclk;
        done_prev  <= done;
        ser_prev   <= sr_ser;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_frame(input logic [W-1:0] d);
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin tick(); n++; end
        if (in_ready !== 1'b1) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    // busy counts clock edges from the acceptance edge to in_ready high again
    task automatic wait_idle(input int start, output int busy);
        busy = start;
        while (in_ready !== 1'b1 && busy < 1000) begin tick(); busy++; end
    endtask

    typedef struct {
        logic       rst;
        logic       oe;
        logic [4:0] exp;   // {srclrn, srclk, rclk, in_ready, oen}
    } vec_t;

    vec_t vec [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy, s0, r0, d0, n;
        logic [W-1:0] d, prev;
        logic oe;

        vec[0] = '{1'b1, 1'b1, 5'b00001};
        vec[1] = '{1'b0, 1'b1, 5'b00001};
        vec[2] = '{1'b0, 1'b1, 5'b01001};
        vec[3] = '{1'b0, 1'b1, 5'b01001};
        vec[4] = '{1'b0, 1'b1, 5'b10101};
        vec[5] = '{1'b0, 1'b1, 5'b10101};
        vec[6] = '{1'b0, 1'b1, 5'b10010};
        vec[7] = '{1'b0, 1'b0, 5'b10011};
        vec[8] = '{1'b0, 1'b1, 5'b10010};

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ser", {31'd0, sr_ser}, 32'd0);
        chk("reset_rd_data", {16'd0, rd_data}, 32'd0);

        // init sequence, cycle by cycle
        for (int i = 0; i < 9; i++) begin
            rst        = vec[i].rst;
            out_enable = vec[i].oe;
            tick();
            chk($sformatf("init_vec%0d", i),
                {27'd0, sr_srclrn, sr_srclk, sr_rclk, in_ready, sr_oen},
                {27'd0, vec[i].exp});
        end
        chk("init_storage", {16'd0, storage}, 32'd0);

        // single frame A55A
        s0 = srclk_rises; r0 = rclk_rises; d0 = done_cnt;
        start_frame(16'hA55A);
        wait_idle(1, busy);
        chk("a55a_busy", busy, BUSY);
        chk("a55a_chip0", {24'd0, storage[7:0]}, 32'h5A);
        chk("a55a_chip1", {24'd0, storage[15:8]}, 32'hA5);
        chk("a55a_srclk_rises", srclk_rises - s0, W);
        chk("a55a_rclk_rises", rclk_rises - r0, 1);
        chk("a55a_done_cnt", done_cnt - d0, 1);

        // back-to-back with in_valid held; in_data changes after acceptance
        d0 = done_cnt;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        in_data = 16'hFFFF;
        wait_idle(1, busy);
        chk("b2b_first_busy", busy, BUSY);
        chk("b2b_first_storage", {16'd0, storage}, 32'h1234);
        tick();
        chk("b2b_accept_first_idle", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_idle(1, busy);
        chk("b2b_second_storage", {16'd0, storage}, 32'hFFFF);
        chk("b2b_done_cnt", done_cnt - d0, 2);

        // out_enable toggling mid-frame
        out_enable = 1'b1;
        start_frame(16'h3C96);
        repeat (10) tick();
        out_enable = 1'b0; tick();
        chk("oe_off", {31'd0, sr_oen}, 32'd1);
        out_enable = 1'b1; tick();
        chk("oe_on", {31'd0, sr_oen}, 32'd0);
        out_enable = 1'b0; tick();
        chk("oe_off2", {31'd0, sr_oen}, 32'd1);
        wait_idle(14, busy);
        chk("oe_busy", busy, BUSY);
        chk("oe_storage", {16'd0, storage}, 32'h3C96);

        // reset in the middle of a frame (bit 7)
        s0 = srclk_rises;
        start_frame(16'hF0F0);
        n = 0;
        while (srclk_rises - s0 < 8 && n < 200) begin tick(); n++; end
        chk("mid_bits_reached", srclk_rises - s0, 8);
        rst = 1'b1;
        tick();
        chk("midrst_outputs", {26'd0, sr_srclrn, sr_srclk, sr_rclk, in_ready, sr_oen, done},
            32'b000010);
        rst = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("midrst_init_len", n, INITLEN);
        chk("midrst_storage", {16'd0, storage}, 32'h0);
        chk("midrst_rd_data", {16'd0, rd_data}, 32'h0);
        start_frame(16'h0001);
        wait_idle(1, busy);
        chk("after_rst_chip0", {24'd0, storage[7:0]}, 32'h01);
        chk("after_rst_chip1", {24'd0, storage[15:8]}, 32'h00);

        // readback pair
        start_frame(16'hBEEF);
        wait_idle(1, busy);
        start_frame(16'h0000);
        wait_idle(1, busy);
        chk("zero_storage", {16'd0, storage}, 32'h0);
`ifdef SR595_READBACK_EN
        chk("readback_beef", {16'd0, rd_data}, 32'hBEEF);
`else
        chk("rd_data_tied", {16'd0, rd_data}, 32'h0);
`endif
        prev = 16'h0000;

        // randomized frames against the reference model
        for (int k = 0; k < 15; k++) begin
            d  = W'($urandom);
            oe = 1'($urandom_range(0, 1));
            out_enable = oe;
            tick();
            chk($sformatf("rnd%0d_oen", k), {31'd0, sr_oen}, {31'd0, ~oe});
            repeat ($urandom_range(0, 3)) tick();
            s0 = srclk_rises; d0 = done_cnt;
            start_frame(d);
            wait_idle(1, busy);
            chk($sformatf("rnd%0d_busy", k), busy, BUSY);
            chk($sformatf("rnd%0d_storage", k), {16'd0, storage}, {16'd0, d});
            chk($sformatf("rnd%0d_shifts", k), srclk_rises - s0, W);
            chk($sformatf("rnd%0d_done", k), done_cnt - d0, 1);
`ifdef SR595_READBACK_EN
            chk($sformatf("rnd%0d_rd_data", k), {16'd0, rd_data}, {16'd0, prev});
`endif
            prev = d;
        end

        chk("done_single_cycle", done_viol, 0);
        chk("ser_stable_while_srclk_high", ser_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr595_chain_ctrl.md
Name: sr595_chain_ctrl

Overview:
- Sequencer that drives a daisy-chain of N_CHIPS 74LV595-style shift/storage register chips from a parallel word.
- Accepts a frame over a valid/ready handshake and serializes it MSB-first on SER/SRCLK at a divided rate.
- Pulses RCLK to transfer the frame to the chip outputs, and manages SRCLRn (clear at init) and OEn.
- Sits between core logic and the board-level 595 chain.

Parameters:
- N_CHIPS, 2, number of chained chips; frame width W = 8*N_CHIPS.
- CLK_DIV, 2, clk cycles per SRCLK/RCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  frame available.
- in_ready  output  1  controller idle, able to accept a frame.
- in_data  input  W  frame; in_data[8k+i] lands on chip k output Q[i] (chip 0 is nearest the controller).
- out_enable  input  1  request chip outputs enabled.
- done  output  1  one-cycle pulse at the end of each frame's latch.
- sr_ser  output  1  to SER of chip 0.
- sr_srclk  output  1  shift clock to all chips.
- sr_rclk  output  1  storage clock to all chips.
- sr_srclrn  output  1  shift clear to all chips, active-low.
- sr_oen  output  1  output enable to all chips, active-low.
- sr_qh  input  1  QH of the last chip; used only with SR595_READBACK_EN, ignored otherwise.
- rd_data  output  W  previous chain contents; only with SR595_READBACK_EN.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, done=0, sr_ser=0, sr_srclk=0, sr_rclk=0, sr_srclrn=0, sr_oen=1, rd_data=0. The FSM enters INIT_LO.
- Phase counter counts 0..CLK_DIV-1; each state below lasts exactly CLK_DIV cycles unless noted.
- INIT_LO: srclrn=0, srclk=0.
- INIT_HI: srclrn=0, srclk=1, which clears all shift regs.
- INIT_LATCH: srclrn=1, rclk=1, which loads zeros to storage. Then IDLE.
- Init length is therefore 3*CLK_DIV cycles after rst deasserts. sr_oen stays 1 throughout init.
- IDLE: in_ready=1, srclk=0, rclk=0.
  - On in_valid && in_ready, in_data is captured into an internal shift reg, in_ready drops the next cycle, bit index is set to W-1, and the FSM goes to SHIFT_LO.
- SHIFT_LO: srclk=0; sr_ser = captured[bit] (stable for the whole state). Then SHIFT_HI.
- SHIFT_HI: srclk=1, the rising edge samples SER; ser is held.
  - If bit==0, go to LATCH; else decrement bit and go to SHIFT_LO.
- LATCH: srclk=0, rclk=1.
  - On its last cycle, done=1 for one cycle, then IDLE with rclk=0.
- Busy time: from the acceptance cycle to in_ready re-asserting is 2*CLK_DIV*W + CLK_DIV + 1 cycles. For N_CHIPS=2, CLK_DIV=2 that is 67.
- sr_oen = 1 until init completes; thereafter sr_oen = ~out_enable registered (1-cycle latency), independent of FSM state.
- in_valid while busy is ignored; the source holds the frame (no loss, no queue). Back-to-back frames: a new frame is accepted on the first IDLE cycle.
- rst mid-frame: outputs return to reset values next edge, the partial frame is discarded, and the init sequence restarts (the chain is cleared and zeros are latched).
- CLK_DIV=1: states are single-cycle; SER still changes only in SHIFT_LO.
- Captured data is never altered by in_data changes after acceptance.

Optional Feature:
- Macro SR595_READBACK_EN.
- Defined:
  - On the last cycle of each SHIFT_LO, sr_qh is sampled into a W-bit capture reg, shifting left (LSB-in).
  - At the done pulse, rd_data is updated with the capture, which is the chain contents from before the frame; the first bit sampled lands in rd_data[W-1].
  - rd_data resets to 0.
- Undefined: sr_qh is unused, and rd_data is tied to 0 with no capture logic.

Test Plan:
- After rst (N_CHIPS=2, CLK_DIV=2):
  - Expect srclrn=0 for 4 cycles with one srclk pulse, then an rclk pulse of 2 cycles.
  - in_ready=1 exactly 6 cycles after rst falls; sr_oen=1 throughout.
- Send in_data=16'hA55A:
  - Behavioural 595 chain model shows chip0 Q=8'h5A and chip1 Q=8'hA5 after done.
  - Exactly 16 srclk rising edges, 1 rclk pulse; in_ready low for 67 cycles.
- Hold in_valid with 16'h1234 then 16'hFFFF back-to-back:
  - Second frame accepted on the first IDLE cycle; final outputs are chip0=8'hFF, chip1=8'hFF.
  - done pulses twice.
- Toggle out_enable 0->1->0 mid-frame: sr_oen follows the inverse one cycle later; shift timing is unaffected.
- Assert rst at bit 7 of a 16'hF0F0 frame:
  - Init sequence reruns and the model outputs are 0.
  - The next frame 16'h0001 produces chip0=8'h01.
- With SR595_READBACK_EN: send 16'hBEEF then 16'h0000; the second done gives rd_data=16'hBEEF.
